// File: rtl/csr_pkg.sv
// Shared constants and helpers for the writeback-stage CSR file:
// addresses, csr_op encodings, access classification and read-modify-write.
package csr_pkg;

    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    typedef enum logic [1:0] {
        CSR_UNIMPL   = 2'd0,
        CSR_WRITABLE = 2'd1,
        CSR_READONLY = 2'd2
    } csr_class_e;

    function automatic csr_class_e csr_class(input logic [11:0] addr);
        csr_class_e cls;
        case (addr)
            CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
                cls = CSR_WRITABLE;
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH, CSR_MHARTID:
                cls = CSR_READONLY;
            default:
                cls = CSR_UNIMPL;
        endcase
        return cls;
    endfunction

    function automatic logic [31:0] csr_apply_op(input logic [1:0]  op,
                                                 input logic [31:0] old,
                                                 input logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            OP_RW:   res = wdata;
            OP_RS:   res = old | wdata;
            OP_RC:   res = old & ~wdata;
            default: res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half loads; a half
// load suppresses the carry that would otherwise cross between the halves.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt
);

    logic [31:0] lo_next;

    assign lo_next = cnt[31:0] + {31'd0, inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 64'd0;
        end else if (wr_lo) begin
            cnt <= {cnt[63:32], wdata};
        end else if (wr_hi) begin
            // Low half still counts; its carry-out is dropped this cycle.
            cnt <= {wdata, lo_next};
        end else begin
            cnt <= cnt + {63'd0, inc};
        end
    end

endmodule

// File: rtl/csr_wb_write.sv
// Machine-mode CSR file updated at writeback: read-modify-write of a small
// set of trap CSRs plus the mcycle/minstret counters and their aliases.
module csr_wb_write
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    // wb_valid has no ready: a retiring instruction is always accepted in the
    // cycle it is presented, and csr_op/csr_addr/csr_wdata are only
    // meaningful while wb_valid is high.

    localparam logic [31:0] MTVEC_INIT = {MTVEC_RESET[31:2], 2'b00};

    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;

    csr_class_e  cls;
    logic        active;
    logic        wants_write;
    logic        we;
    logic [31:0] old_val;
    logic [31:0] new_val;

    logic we_mtvec, we_mscratch, we_mepc, we_mcause;
    logic we_mcycle, we_mcycleh, we_minstret, we_minstreth;
    logic instret_inc;

    assign cls         = csr_class(csr_addr);
    assign active      = wb_valid && (csr_op != OP_NONE);
    assign wants_write = (csr_op == OP_RW) || (csr_wdata != 32'd0);

    assign csr_illegal = active && ((cls == CSR_UNIMPL) ||
                                    ((cls == CSR_READONLY) && wants_write));
    assign we          = active && (cls == CSR_WRITABLE) && wants_write;

    always_comb begin
        old_val = 32'd0;
        case (csr_addr)
            CSR_MTVEC:                    old_val = mtvec;
            CSR_MSCRATCH:                 old_val = mscratch;
            CSR_MEPC:                     old_val = mepc;
            CSR_MCAUSE:                   old_val = mcause;
            CSR_MCYCLE,   CSR_CYCLE:      old_val = cycle_cnt[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:     old_val = cycle_cnt[63:32];
            CSR_MINSTRET, CSR_INSTRET:    old_val = instret_cnt[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:  old_val = instret_cnt[63:32];
            CSR_MHARTID:                  old_val = HART_ID;
            default:                      old_val = 32'd0;
        endcase
    end

    assign csr_rdata = csr_illegal ? 32'd0 : old_val;
    assign new_val   = csr_apply_op(csr_op, old_val, csr_wdata);

    assign we_mtvec     = we && (csr_addr == CSR_MTVEC);
    assign we_mscratch  = we && (csr_addr == CSR_MSCRATCH);
    assign we_mepc      = we && (csr_addr == CSR_MEPC);
    assign we_mcause    = we && (csr_addr == CSR_MCAUSE);
    assign we_mcycle    = we && (csr_addr == CSR_MCYCLE);
    assign we_mcycleh   = we && (csr_addr == CSR_MCYCLEH);
    assign we_minstret  = we && (csr_addr == CSR_MINSTRET);
    assign we_minstreth = we && (csr_addr == CSR_MINSTRETH);

    // An instruction that loads minstret itself is not counted on top.
    assign instret_inc = wb_valid && !we_minstret && !we_minstreth;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtvec    <= MTVEC_INIT;
            mscratch <= 32'd0;
            mepc     <= 32'd0;
            mcause   <= 32'd0;
        end else begin
            if (we_mtvec)    mtvec    <= {new_val[31:2], 2'b00};
            if (we_mscratch) mscratch <= new_val;
            if (we_mepc)     mepc     <= {new_val[31:2], 2'b00};
            if (we_mcause)   mcause   <= new_val;
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (we_mcycle),
        .wr_hi (we_mcycleh),
        .wdata (new_val),
        .cnt   (cycle_cnt)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret_inc),
        .wr_lo (we_minstret),
        .wr_hi (we_minstreth),
        .wdata (new_val),
        .cnt   (instret_cnt)
    );

endmodule
